skew_fanout_pipe: RTL

- Parametrised successor to the aligned fanout replicator that feeds the attention and butterfly engines.
- Replicates one upstream beat onto FANOUT lanes through a DEPTH-stage elastic pipeline with full valid/ready backpressure.
- Adds an optional per-lane beat skew (lane i lags by i beats) for systolic feeding, plus a drain sequence that flushes skewed data.
- Sits between the on-chip buffer read port and PE-array row inputs.

---
 rtl/fanout_pkg.sv | 13 +
 rtl/elastic_stage.sv | 34 +++
 rtl/skew_fanout_pipe.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fanout_pkg.sv
// Shared definitions for the skewed fanout pipeline: FSM states and lane slicing.
package fanout_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fanout_state_t;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One valid/ready register stage; loads whenever empty or when downstream takes its beat.
module elastic_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_vld,
    output logic         o_rdy,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic [W-1:0] o_dat
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    assign o_rdy = ~r_vld | i_rdy;
    assign o_vld = r_vld;
    assign o_dat = r_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (o_rdy) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_dat <= i_dat;
            end
        end
    end

endmodule

// File: rtl/skew_fanout_pipe.sv
// Replicates one upstream beat onto FANOUT lanes through an elastic pipeline, with optional
// per-lane systolic skew and a drain sequence. States: RUN | normal flow ; DRAIN | flushing skew slots.
module skew_fanout_pipe
    import fanout_pkg::*;
#(
    parameter int DATA_W = 1024,
    parameter int FANOUT = 3,
    parameter int DEPTH  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     skew_en,
    input  logic [FANOUT-1:0]        lane_mask,
    input  logic                     drain,
    input  logic                     up_vld,
    input  logic [DATA_W-1:0]        up_dat,
    output logic                     up_rdy,
    output logic                     dn_vld,
    input  logic                     dn_rdy,
    output logic [FANOUT*DATA_W-1:0] dn_dat,
    output logic [FANOUT-1:0]        dn_lane_vld,
    output logic                     busy
);

    localparam int CNT_W = $clog2(FANOUT + 1);
    localparam int LW    = FANOUT * DATA_W;

    fanout_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [DEPTH:0]   w_vld;
    logic [DEPTH:0]   w_rdy;
    logic [LW-1:0]    w_dat [DEPTH+1];
    logic [LW-1:0]    w_head;
    logic             w_run;
    logic             w_pipe_busy;
    logic             w_drain_phase;
    logic             w_xfer;
    logic [FANOUT-1:0] w_slot_any;

    assign w_run    = (r_state == RUN);
    assign w_vld[0] = up_vld & w_run;
    assign w_dat[0] = {FANOUT{up_dat}};
    assign up_rdy   = w_rdy[0] & w_run;
    assign w_rdy[DEPTH] = dn_rdy;

    // Each stage carries all FANOUT copies so no single register drives every lane.
    for (genvar gk = 0; gk < DEPTH; gk++) begin : g_stage
        elastic_stage #(.W(LW)) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_vld (w_vld[gk]),
            .o_rdy (w_rdy[gk]),
            .i_dat (w_dat[gk]),
            .o_vld (w_vld[gk+1]),
            .i_rdy (w_rdy[gk+1]),
            .o_dat (w_dat[gk+1])
        );
    end

    assign w_head        = w_dat[DEPTH];
    assign w_pipe_busy   = |w_vld[DEPTH:1];
    assign w_drain_phase = (r_state == DRAIN) & ~w_pipe_busy;
    assign dn_vld        = w_vld[DEPTH] | w_drain_phase;
    assign w_xfer        = dn_vld & dn_rdy;
    assign busy          = w_pipe_busy | (r_state == DRAIN) | (|w_slot_any);

    for (genvar gi = 0; gi < FANOUT; gi++) begin : g_lane
        logic [DATA_W-1:0] w_lane_dat;
        logic              w_lane_fill;
        logic              w_show;

        if (gi == 0) begin : g_direct
            assign w_lane_dat    = w_head[lane_lsb(0, DATA_W) +: DATA_W];
            assign w_lane_fill   = w_vld[DEPTH];
            assign w_slot_any[0] = 1'b0;
        end else begin : g_chain
            logic [DATA_W-1:0] r_sd [gi];
            logic [gi-1:0]     r_sf;
            logic [DATA_W-1:0] w_in_dat;

            // Drain beats shift an empty marker in behind the last real beat.
            assign w_in_dat = w_drain_phase ? '0 : w_head[lane_lsb(gi, DATA_W) +: DATA_W];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < gi; j++) begin
                        r_sd[j] <= '0;
                        r_sf[j] <= 1'b0;
                    end
                end else if (w_xfer && skew_en) begin
                    r_sd[0] <= w_in_dat;
                    r_sf[0] <= ~w_drain_phase;
                    for (int j = 1; j < gi; j++) begin
                        r_sd[j] <= r_sd[j-1];
                        r_sf[j] <= r_sf[j-1];
                    end
                end
            end

            assign w_lane_dat     = r_sd[gi-1];
            assign w_lane_fill    = r_sf[gi-1];
            assign w_slot_any[gi] = |r_sf;
        end

        assign w_show = dn_vld & lane_mask[gi] & (skew_en ? w_lane_fill : 1'b1);
        assign dn_lane_vld[gi] = w_show;
        assign dn_dat[lane_lsb(gi, DATA_W) +: DATA_W] =
            w_show ? (skew_en ? w_lane_dat : w_head[lane_lsb(gi, DATA_W) +: DATA_W]) : '0;
    end

    // Drain beats are counted only once the pipeline has emptied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (drain && skew_en && (FANOUT > 1)) begin
                        r_state <= DRAIN;
                        r_cnt   <= CNT_W'(FANOUT - 1);
                    end
                end
                DRAIN: begin
                    if (w_drain_phase && dn_rdy) begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= RUN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule
